// File: rtl/quad_step_decoder.sv
// Quadrature step receiver: synchroniser + debounce per phase, Gray-transition FSM,
// wrapping position counter and direction glyph. Define QDEC_X1_EN for x1 decoding.
module quad_step_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             c,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic [6:0]       seg,
    output logic             h
);

    localparam int         CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [6:0] SEG_UP  = 7'b0111110;
    localparam logic [6:0] SEG_DN  = 7'b1011110;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] a_sync, b_sync;
    logic [1:0]             sync_ab;
    logic [1:0]             filt_ab;
    logic [CNT_W-1:0]       deb_cnt [2];

    state_t           state, state_next;
    logic [WIDTH-1:0] q_next;
    logic             dir_next, step_next, err_next;
    logic             cnt_up, cnt_dn;

    assign h = 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
        end
    end

    assign sync_ab = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    // A level is accepted only after DEB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            filt_ab <= 2'b00;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_ab[i] != filt_ab[i]) begin
                    if (deb_cnt[i] == CNT_MAX) begin
                        filt_ab[i] <= sync_ab[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    function automatic state_t up_of(input state_t s);
        state_t r;
        r = S00;
        unique case (s)
            S00: r = S10;
            S10: r = S11;
            S11: r = S01;
            S01: r = S00;
        endcase
        return r;
    endfunction

    function automatic state_t down_of(input state_t s);
        state_t r;
        r = S00;
        unique case (s)
            S00: r = S01;
            S01: r = S11;
            S11: r = S10;
            S10: r = S00;
        endcase
        return r;
    endfunction

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state <= S00;
            q     <= '0;
            dir   <= 1'b1;
            step  <= 1'b0;
            err   <= 1'b0;
            seg   <= SEG_UP;
        end else begin
            state <= state_next;
            q     <= q_next;
            dir   <= dir_next;
            step  <= step_next;
            err   <= err_next;
            seg   <= dir_next ? SEG_UP : SEG_DN;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state_t'(filt_ab);
        q_next     = q;
        dir_next   = dir;
        step_next  = 1'b0;
        err_next   = 1'b0;
        cnt_up     = 1'b0;
        cnt_dn     = 1'b0;

        if (state_next != state) begin
            if (state_next == up_of(state)) begin
                dir_next = 1'b1;
`ifdef QDEC_X1_EN
                cnt_up   = (state == S01);
`else
                cnt_up   = 1'b1;
`endif
            end else if (state_next == down_of(state)) begin
                dir_next = 1'b0;
`ifdef QDEC_X1_EN
                cnt_dn   = (state == S10);
`else
                cnt_dn   = 1'b1;
`endif
            end else begin
                err_next = 1'b1;
            end
        end

        if (cnt_up) begin
            q_next    = q + WIDTH'(1);
            step_next = 1'b1;
        end else if (cnt_dn) begin
            q_next    = q - WIDTH'(1);
            step_next = 1'b1;
        end

        // Clear overrides the count but not the step pulse or direction.
        if (clr) q_next = '0;
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed self-checking bench for quad_step_decoder (WIDTH=4, SYNC_STAGES=2, DEB_CYCLES=4).
// Build with QDEC_X1_EN defined to exercise the x1 decoding variant.
module tb_quad_step_decoder;

    logic       c = 1'b0;
    logic       rst, a_in, b_in, clr;
    logic [3:0] q;
    logic       dir, step, err, h;
    logic [6:0] seg;

    int n_cmp = 0;
    int n_bad = 0;
    int step_cnt = 0;
    int err_cnt = 0;
    int base_s, base_e;

    quad_step_decoder #(.WIDTH(4), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut (
        .c(c), .rst(rst), .a_in(a_in), .b_in(b_in), .clr(clr),
        .q(q), .dir(dir), .step(step), .err(err), .seg(seg), .h(h)
    );

    always #5 c = ~c;

    always @(negedge c) begin
        if (step === 1'b1) step_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic set_ab(input logic a, input logic b, input int hold);
        @(negedge c);
        a_in = a;
        b_in = b;
        repeat (hold) @(negedge c);
    endtask

    task automatic test_reset;
        rst = 1'b1; a_in = 1'b0; b_in = 1'b0; clr = 1'b0;
        #2;
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL rst_q: got %0d want 0", q); end
        n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL rst_dir: got %b want 1", dir); end
        n_cmp++; if ({step, err} !== 2'b00) begin n_bad++; $display("FAIL rst_pulses: got %b want 00", {step, err}); end
        n_cmp++; if (seg !== 7'b0111110) begin n_bad++; $display("FAIL rst_seg: got %b want 0111110", seg); end
        n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL rst_h: got %b want 1", h); end
        repeat (2) @(negedge c);
        rst = 1'b0;
        repeat (4) @(negedge c);
    endtask

    task automatic test_up_cycle;
        base_s = step_cnt; base_e = err_cnt;
        @(negedge c);
        a_in = 1'b1; b_in = 1'b0;
        repeat (6) @(posedge c);
        #1;
        n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL step_early: got %b want 0 at k+5", step); end
        @(posedge c);
        #1;
        n_cmp++; if (step !== 1'b1) begin n_bad++; $display("FAIL step_k6: got %b want 1 at k+6", step); end
        n_cmp++; if (q !== 4'd1) begin n_bad++; $display("FAIL q_k6: got %0d want 1", q); end
        repeat (8) @(negedge c);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b0, 1'b0, 10);
        n_cmp++; if (q !== 4'd4) begin n_bad++; $display("FAIL up_q: got %0d want 4", q); end
        n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL up_dir: got %b want 1", dir); end
        n_cmp++; if (step_cnt - base_s !== 4) begin n_bad++; $display("FAIL up_steps: got %0d want 4", step_cnt - base_s); end
        n_cmp++; if (err_cnt - base_e !== 0) begin n_bad++; $display("FAIL up_errs: got %0d want 0", err_cnt - base_e); end
    endtask

    task automatic test_down_wrap;
        @(negedge c); clr = 1'b1;
        @(negedge c); clr = 1'b0;
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL clr_q: got %0d want 0", q); end
        base_s = step_cnt;
        set_ab(1'b0, 1'b1, 10);
        n_cmp++; if (q !== 4'd15) begin n_bad++; $display("FAIL dn_wrap_q: got %0d want 15", q); end
        n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL dn_dir: got %b want 0", dir); end
        n_cmp++; if (seg !== 7'b1011110) begin n_bad++; $display("FAIL dn_seg: got %b want 1011110", seg); end
        n_cmp++; if (step_cnt - base_s !== 1) begin n_bad++; $display("FAIL dn_steps: got %0d want 1", step_cnt - base_s); end
    endtask

    task automatic test_glitch;
        base_s = step_cnt; base_e = err_cnt;
        @(negedge c); a_in = 1'b1;
        repeat (3) @(negedge c);
        a_in = 1'b0;
        repeat (12) @(negedge c);
        n_cmp++; if (q !== 4'd15) begin n_bad++; $display("FAIL glitch_q: got %0d want 15", q); end
        n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL glitch_dir: got %b want 0", dir); end
        n_cmp++; if ((step_cnt - base_s) + (err_cnt - base_e) !== 0) begin
            n_bad++; $display("FAIL glitch_pulses: got %0d want 0", (step_cnt - base_s) + (err_cnt - base_e));
        end
    endtask

    task automatic test_two_bit;
        set_ab(1'b0, 1'b0, 10);
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL up_wrap_q: got %0d want 0", q); end
        base_s = step_cnt; base_e = err_cnt;
        set_ab(1'b1, 1'b1, 10);
        n_cmp++; if (err_cnt - base_e !== 1) begin n_bad++; $display("FAIL jump_errs: got %0d want 1", err_cnt - base_e); end
        n_cmp++; if (step_cnt - base_s !== 0) begin n_bad++; $display("FAIL jump_steps: got %0d want 0", step_cnt - base_s); end
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL jump_q: got %0d want 0", q); end
        n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL jump_dir: got %b want 1", dir); end
    endtask

    task automatic test_mid_reset;
        set_ab(1'b1, 1'b0, 10);
        n_cmp++; if ({q, dir} !== {4'd15, 1'b0}) begin n_bad++; $display("FAIL pre_rst: got q=%0d dir=%b want q=15 dir=0", q, dir); end
        @(negedge c);
        a_in = 1'b0; b_in = 1'b0;
        repeat (3) @(posedge c);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL mid_rst_q: got %0d want 0", q); end
        n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL mid_rst_dir: got %b want 1", dir); end
        n_cmp++; if ({step, err} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_pulses: got %b want 00", {step, err}); end
        n_cmp++; if ({seg, h} !== {7'b0111110, 1'b1}) begin n_bad++; $display("FAIL mid_rst_seg: got %b want 01111101", {seg, h}); end
        @(negedge c);
        rst = 1'b0;
        base_s = step_cnt;
        repeat (12) @(negedge c);
        n_cmp++; if (q !== 4'd0 || step_cnt != base_s) begin
            n_bad++; $display("FAIL post_rst: got q=%0d steps=%0d want q=0 steps=0", q, step_cnt - base_s);
        end
    endtask

    task automatic test_clr_collision;
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b0, 1'b0, 10);
        n_cmp++; if (q !== 4'd4) begin n_bad++; $display("FAIL pre_clr_q: got %0d want 4", q); end
        base_s = step_cnt;
        @(negedge c);
        a_in = 1'b1; b_in = 1'b0;
        repeat (6) @(posedge c);
        @(negedge c); clr = 1'b1;
        @(negedge c);
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL clr_win_q: got %0d want 0", q); end
        n_cmp++; if (step !== 1'b1) begin n_bad++; $display("FAIL clr_step: got %b want 1", step); end
        clr = 1'b0;
        repeat (10) @(negedge c);
        n_cmp++; if (q !== 4'd0 || step_cnt - base_s !== 1) begin
            n_bad++; $display("FAIL clr_after: got q=%0d steps=%0d want q=0 steps=1", q, step_cnt - base_s);
        end
    endtask

    task automatic test_x1;
        base_s = step_cnt;
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b0, 1'b1, 10);
        n_cmp++; if (q !== 4'd0 || step_cnt != base_s) begin
            n_bad++; $display("FAIL x1_partial: got q=%0d steps=%0d want q=0 steps=0", q, step_cnt - base_s);
        end
        set_ab(1'b0, 1'b0, 10);
        n_cmp++; if (q !== 4'd1) begin n_bad++; $display("FAIL x1_up_q: got %0d want 1", q); end
        n_cmp++; if (step_cnt - base_s !== 1) begin n_bad++; $display("FAIL x1_up_steps: got %0d want 1", step_cnt - base_s); end
        set_ab(1'b0, 1'b1, 10);
        n_cmp++; if ({q, dir} !== {4'd1, 1'b0}) begin n_bad++; $display("FAIL x1_dn_first: got q=%0d dir=%b want q=1 dir=0", q, dir); end
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b0, 1'b0, 10);
        n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL x1_dn_q: got %0d want 0", q); end
        n_cmp++; if (step_cnt - base_s !== 2) begin n_bad++; $display("FAIL x1_dn_steps: got %0d want 2", step_cnt - base_s); end
    endtask

    initial begin
        test_reset;
`ifdef QDEC_X1_EN
        test_x1;
`else
        test_up_cycle;
        test_down_wrap;
        test_glitch;
        test_two_bit;
        test_mid_reset;
        test_clr_collision;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
